// File: rtl/aww_dcache_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : aww_dcache_if                                                     |
// | Purpose  : MEM-stage request bus and memory-controller bus of the D-cache    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface aww_dcache_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  // slave: the cache itself; master: pipeline + memory controller environment
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

`default_nettype wire

// File: rtl/aww_dcache.sv
// +-----------------------------------------------------------------------------+
// | Module   : aww_dcache                                                        |
// | Purpose  : direct-mapped write-back write-allocate data cache, flush on halt |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module aww_dcache #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS)
) (
  input  wire logic   CLK,
  input  wire logic   nRST,
  aww_dcache_if.slave bus
);
  localparam int               TAG_W    = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    FETCH  = 3'd2,
    FLUSH  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req, hit;
  logic             wr_hit, fill, clr_dirty;
  logic [IDX_W-1:0] clr_idx;
  logic             dhit, dren, dwen, flushed;
  logic [31:0]      dmemload, daddr, dstore;
  logic             unused_addr_bits;

  assign idx              = bus.dmemaddr[IDX_W+1:2];
  assign tag              = bus.dmemaddr[31:IDX_W+2];
  assign req              = bus.dmemREN | bus.dmemWEN;
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_bits = ^bus.dmemaddr[1:0];

  always_comb begin
    state_d   = state_q;
    fidx_d    = fidx_q;
    wr_hit    = 1'b0;
    fill      = 1'b0;
    clr_dirty = 1'b0;
    clr_idx   = idx;
    dhit      = 1'b0;
    dren      = 1'b0;
    dwen      = 1'b0;
    flushed   = 1'b0;
    dmemload  = '0;
    daddr     = '0;
    dstore    = '0;
    case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = FLUSH;
        end else if (req) begin
          if (hit) begin
            dhit = 1'b1;
            // REN+WEN together is serviced as a store
            if (bus.dmemWEN) wr_hit = 1'b1;
            else             dmemload = data_q[idx];
          end else if (dirty_q[idx]) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB: begin
        dwen   = 1'b1;
        daddr  = {tag_q[idx], idx, 2'b00};
        dstore = data_q[idx];
        if (!bus.dwait) begin
          clr_dirty = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        dren  = 1'b1;
        daddr = {bus.dmemaddr[31:2], 2'b00};
        if (!bus.dwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        clr_idx = fidx_q;
        if (dirty_q[fidx_q]) begin
          dwen   = 1'b1;
          daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
          dstore = data_q[fidx_q];
          if (!bus.dwait) clr_dirty = 1'b1;
        end
        // a clean line advances immediately; a dirty one once its write lands
        if (!dirty_q[fidx_q] || !bus.dwait) begin
          fidx_d = fidx_q + IDX_W'(1);
          if (fidx_q == LAST_IDX) state_d = HALTED;
        end
      end
      HALTED: begin
        flushed = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (wr_hit)    dirty_q[idx]     <= 1'b1;
      if (clr_dirty) dirty_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[idx] <= bus.dload;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx] <= bus.dmemstore;
    end
  end

  assign bus.dhit     = dhit;
  assign bus.dmemload = dmemload;
  assign bus.flushed  = flushed;
  assign bus.dREN     = dren;
  assign bus.dWEN     = dwen;
  assign bus.daddr    = daddr;
  assign bus.dstore   = dstore;

endmodule

`default_nettype wire

// File: doc/aww_dcache.md
Name: aww_dcache

Overview:
- Data-cache responder for the MEM stage. The MEM stage is the initiator: it drives dmemREN/dmemWEN from its DataRead/DataWrite control bits, plus aluout as the address and rdat2 as the store data.
- Direct-mapped, write-back, write-allocate cache with one-word blocks. It sits between the pipeline and the memory controller and stalls the pipeline by withholding dhit.
- On halt it flushes every dirty line to memory, then asserts flushed.

Parameters:
- SETS, 16, number of lines; power of two, 2..256.
- IDX_W, $clog2(SETS), index width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous reset, active-low.
- dmemREN  in  1  MEM-stage read request.
- dmemWEN  in  1  MEM-stage write request.
- dmemaddr  in  32  byte address; bits [1:0] ignored.
- dmemstore  in  32  store data.
- halt  in  1  pipeline halted; level signal.
- dhit  out  1  request completed this cycle.
- dmemload  out  32  read data, valid when dhit && dmemREN.
- flushed  out  1  flush complete; sticky until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dload  in  32  memory read data, valid when dREN && !dwait.
- dwait  in  1  memory busy; a transfer completes on the cycle dwait=0.

Behaviour:
Address decode and line state:
- idx = dmemaddr[IDX_W+1:2]; tag = dmemaddr[31:IDX_W+2].
- Each line holds valid, dirty, tag and data.

Reset:
- nRST low asynchronously clears all valid and dirty bits, sets state IDLE, flush index 0, flushed 0.
- All outputs are 0 during reset. Data and tag arrays need not be reset.

States: IDLE, WB, FETCH, FLUSH, HALTED.

IDLE:
- halt has priority over any request and moves the FSM to FLUSH.
- A request is req = dmemREN|dmemWEN. If both REN and WEN are set, treat it as a write.
- hit = valid[idx] && tag match.
- On hit, dhit=1 combinationally in the same cycle.
  - Read: dmemload = line data.
  - Write: line data <= dmemstore and dirty <= 1 at the clock edge.
- When dhit=0, dmemload=0.
- On miss with valid && dirty: go to WB. Otherwise go to FETCH.

WB:
- dWEN=1, daddr = {victim tag, idx, 2'b00}, dstore = victim data.
- Hold until dwait=0, then clear dirty and go to FETCH.

FETCH:
- dREN=1, daddr = {dmemaddr[31:2], 2'b00}.
- On dwait=0: install dload, valid=1, dirty=0, new tag; go to IDLE.
- The request is then serviced as a hit on the next cycle.
- If the request drops mid-FETCH, the fill still completes.

Latency and stalling:
- Hit: 0 extra cycles.
- Clean miss: FETCH cycles + 1.
- Dirty miss: WB + FETCH cycles + 1.
- dhit is 0 in every state except IDLE.

FLUSH:
- Walk the flush index from 0 to SETS-1.
- Dirty line: dWEN=1 with its address and data until dwait=0, then clear dirty and increment the index.
- Clean line: one cycle, no memory traffic.
- After index SETS-1 completes, go to HALTED.

HALTED:
- flushed=1, no memory traffic, dhit=0. Stays here until reset.
- halt deasserting in FLUSH or HALTED has no effect.

Memory-port rules:
- dREN and dWEN are never both 1.
- daddr and dstore are 0 when neither is set.
- No combinational path from dwait to dREN or dWEN.

Reset mid-operation: returns to IDLE immediately and drops dREN/dWEN in the same cycle. Lines are lost.

Test Plan:
1. Reset, then read addr 0x100 with dwait=1 for 3 cycles and dload=0xDEADBEEF. Required:
   - dREN=1 with daddr=0x100 for 4 cycles.
   - Next cycle: dhit=1, dmemload=0xDEADBEEF.
   - Re-reading 0x100 gives dhit in the same cycle.
2. Write 0x55 to 0x100 (hit after scenario 1). Then read 0x140 (same idx, SETS=16). Required:
   - dWEN=1 with daddr=0x100 and dstore=0x55.
   - Then dREN with daddr=0x140.
   - dhit=0 throughout the miss.
3. Dirty lines at idx 1 and 5, then halt=1 with dwait=0. Required:
   - Exactly two dWEN cycles, with addresses of idx 1 then idx 5.
   - flushed=1 after 16 scan slots.
   - A simultaneous dmemREN is never hit.
4. dmemREN=dmemWEN=1 on a hit at 0x8, store 0xAB. Required: treated as a write; dirty set; a subsequent read returns 0xAB.
5. nRST pulsed low during FETCH with dwait=1. Required:
   - dREN=0 immediately.
   - Re-reading the same address misses again and triggers FETCH.
6. dmemREN dropped during FETCH. Required:
   - Fill completes; line becomes valid.
   - A later read of the same address hits with 0 stall.
